// File: rtl/riscv_ctrl_pkg.sv
// Shared pipeline-control types and constants for the hazard unit and its helpers.
package riscv_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } hz_state_t;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int          REG_AW_DEF = 5;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: decode reads a register that the load in execute will write.
module load_use_detect
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] de_rs1,
  input  logic [REG_AW-1:0] de_rs2,
  input  logic              de_use_rs1,
  input  logic              de_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic              ex_reg_wr,
  output logic              hazard
);

  logic w_rd_live;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is hardwired to zero, so a load targeting it can never create a dependency
  assign w_rd_live = ex_is_load & ex_reg_wr & (ex_rd != {REG_AW{1'b0}});
  assign w_rs1_hit = de_use_rs1 & (de_rs1 == ex_rd);
  assign w_rs2_hit = de_use_rs2 & (de_rs2 == ex_rd);
  assign hazard    = w_rd_live & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for PC, F/DE and DE/EX; memory wait > branch flush > load-use.
// Optional performance counters are enabled by defining HAZ_PERF_CNT_EN.
module hazard_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1,
  parameter int MEM_TIMEOUT  = 64,
  parameter int REG_AW       = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] de_rs1,
  input  logic [REG_AW-1:0] de_rs2,
  input  logic              de_use_rs1,
  input  logic              de_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic              ex_reg_wr,
  input  logic              br_taken,
  input  logic              dmem_req,
  input  logic              dmem_ack,
  output logic              stall_pc,
  output logic              stall_fd,
  output logic              stall_dx,
  output logic              flush_fd,
  output logic              flush_dx,
  output logic              mem_err,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);

  localparam int              TW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0]   TMO      = TW'(MEM_TIMEOUT);
  localparam logic [1:0]      BUB_INIT = 2'(LOAD_BUBBLES - 1);

  hz_state_t     r_state;
  hz_state_t     w_state_nxt;
  logic [TW-1:0] r_tcnt;
  logic [TW-1:0] w_tcnt_nxt;
  logic [1:0]    r_bcnt;
  logic [1:0]    w_bcnt_nxt;
  logic          r_mem_err;
  logic          w_err_set;
  logic          w_hazard;
  logic          w_mem_stall;
  logic          w_stall_pc;
  logic          w_stall_fd;
  logic          w_stall_dx;
  logic          w_flush_fd;
  logic          w_flush_dx;

  load_use_detect #(.REG_AW(REG_AW)) u_lud (
    .de_rs1     (de_rs1),
    .de_rs2     (de_rs2),
    .de_use_rs1 (de_use_rs1),
    .de_use_rs2 (de_use_rs2),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .ex_reg_wr  (ex_reg_wr),
    .hazard     (w_hazard)
  );

  assign w_mem_stall = dmem_req & ~dmem_ack;

  // next-state and same-cycle stall/flush decode
  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_bcnt_nxt  = r_bcnt;
    w_err_set   = 1'b0;
    w_stall_pc  = 1'b0;
    w_stall_fd  = 1'b0;
    w_stall_dx  = 1'b0;
    w_flush_fd  = 1'b0;
    w_flush_dx  = 1'b0;
    case (r_state)
      RUN, LOAD_STALL: begin
        if (w_mem_stall) begin
          w_stall_pc  = 1'b1;
          w_stall_fd  = 1'b1;
          w_stall_dx  = 1'b1;
          w_state_nxt = MEM_WAIT;
          w_tcnt_nxt  = TW'(1);
          w_bcnt_nxt  = 2'd0;
        end else if (br_taken) begin
          w_flush_fd  = 1'b1;
          w_flush_dx  = 1'b1;
          w_state_nxt = RUN;
          w_bcnt_nxt  = 2'd0;
        end else if ((r_state == LOAD_STALL) || w_hazard) begin
          w_stall_pc = 1'b1;
          w_stall_fd = 1'b1;
          w_flush_dx = 1'b1;
          if (r_state == LOAD_STALL) begin
            w_bcnt_nxt  = r_bcnt - 2'd1;
            w_state_nxt = (r_bcnt == 2'd1) ? RUN : LOAD_STALL;
          end else if (LOAD_BUBBLES > 1) begin
            w_bcnt_nxt  = BUB_INIT;
            w_state_nxt = LOAD_STALL;
          end else begin
            w_state_nxt = RUN;
          end
        end else begin
          w_state_nxt = RUN;
        end
      end
      MEM_WAIT: begin
        // the ack cycle itself is quiet; a held branch flushes on the following cycle
        if (dmem_ack) begin
          w_state_nxt = RUN;
          w_tcnt_nxt  = {TW{1'b0}};
        end else if (r_tcnt >= TMO) begin
          w_err_set   = 1'b1;
          w_state_nxt = RUN;
          w_tcnt_nxt  = {TW{1'b0}};
        end else begin
          w_stall_pc = 1'b1;
          w_stall_fd = 1'b1;
          w_stall_dx = 1'b1;
          w_tcnt_nxt = r_tcnt + TW'(1);
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_tcnt_nxt  = {TW{1'b0}};
        w_bcnt_nxt  = 2'd0;
      end
    endcase
  end

  // state, counters and sticky timeout flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= RUN;
      r_tcnt    <= {TW{1'b0}};
      r_bcnt    <= 2'd0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_mem_err <= r_mem_err | w_err_set;
    end
  end

  assign stall_pc = rst & w_stall_pc;
  assign stall_fd = rst & w_stall_fd;
  assign stall_dx = rst & w_stall_dx;
  assign flush_fd = rst & w_flush_fd;
  assign flush_dx = rst & w_flush_dx;
  assign mem_err  = rst & r_mem_err;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // free-running event counters, wrapping naturally at 2^32
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      r_stall_cnt <= r_stall_cnt + {31'd0, stall_pc};
      r_flush_cnt <= r_flush_cnt + {31'd0, flush_fd};
    end
  end

  assign stall_cnt = rst ? r_stall_cnt : 32'd0;
  assign flush_cnt = rst ? r_flush_cnt : 32'd0;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table vectors, corner sequences and random stimulus vs a reference model.
module tb_hazard_ctrl;

  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] de_rs1, de_rs2, ex_rd;
  logic       de_use_rs1, de_use_rs2, ex_is_load, ex_reg_wr, br_taken, dmem_req, dmem_ack;

  logic        a_spc, a_sfd, a_sdx, a_ffd, a_fdx, a_err;
  logic        b_spc, b_sfd, b_sdx, b_ffd, b_fdx, b_err;
  logic [31:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
  logic [5:0]  v1, v3;

  assign v1 = {a_spc, a_sfd, a_sdx, a_ffd, a_fdx, a_err};
  assign v3 = {b_spc, b_sfd, b_sdx, b_ffd, b_fdx, b_err};

  hazard_ctrl #(.LOAD_BUBBLES(1), .MEM_TIMEOUT(TMO), .REG_AW(5)) u_dut1 (
    .clk(clk), .rst(rst), .de_rs1(de_rs1), .de_rs2(de_rs2), .de_use_rs1(de_use_rs1),
    .de_use_rs2(de_use_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_reg_wr(ex_reg_wr),
    .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .stall_pc(a_spc), .stall_fd(a_sfd), .stall_dx(a_sdx), .flush_fd(a_ffd), .flush_dx(a_fdx),
    .mem_err(a_err), .stall_cnt(a_scnt), .flush_cnt(a_fcnt));

  hazard_ctrl #(.LOAD_BUBBLES(3), .MEM_TIMEOUT(TMO), .REG_AW(5)) u_dut3 (
    .clk(clk), .rst(rst), .de_rs1(de_rs1), .de_rs2(de_rs2), .de_use_rs1(de_use_rs1),
    .de_use_rs2(de_use_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_reg_wr(ex_reg_wr),
    .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .stall_pc(b_spc), .stall_fd(b_sfd), .stall_dx(b_sdx), .flush_fd(b_ffd), .flush_dx(b_fdx),
    .mem_err(b_err), .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

  int checks = 0;
  int failures = 0;

  // Reference model: per instance, cycles spent waiting on memory, bubbles still owed, sticky error, counts.
  int          lbs [2] = '{1, 3};
  int          m_wait [2];
  int          m_bub [2];
  logic        m_err [2];
  logic [31:0] m_scnt [2];
  logic [31:0] m_fcnt [2];

  // vector bits: [5]stall_pc [4]stall_fd [3]stall_dx [2]flush_fd [1]flush_dx [0]mem_err
  localparam logic [5:0] E_IDLE = 6'b000000;
  localparam logic [5:0] E_BUB  = 6'b110010;
  localparam logic [5:0] E_FL   = 6'b000110;
  localparam logic [5:0] E_MEM  = 6'b111000;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic spec_hazard();
    return ex_is_load && ex_reg_wr && (ex_rd != 5'd0) &&
           ((de_use_rs1 && de_rs1 == ex_rd) || (de_use_rs2 && de_rs2 == ex_rd));
  endfunction

  function automatic logic [5:0] model_out(input int i);
    logic [5:0] e;
    e = E_IDLE;
    if (!rst) return E_IDLE;
    if (m_wait[i] > 0) begin
      if (!dmem_ack && m_wait[i] < TMO) e = E_MEM;
    end else if (dmem_req && !dmem_ack) e = E_MEM;
    else if (br_taken) e = E_FL;
    else if (m_bub[i] > 0 || spec_hazard()) e = E_BUB;
    e[0] = m_err[i];
    return e;
  endfunction

  task automatic model_update(input int i, input logic [5:0] e);
    if (!rst) begin
      m_wait[i] = 0; m_bub[i] = 0; m_err[i] = 1'b0; m_scnt[i] = 32'd0; m_fcnt[i] = 32'd0;
    end else begin
      m_scnt[i] = m_scnt[i] + {31'd0, e[5]};
      m_fcnt[i] = m_fcnt[i] + {31'd0, e[2]};
      if (m_wait[i] > 0) begin
        if (dmem_ack) m_wait[i] = 0;
        else if (m_wait[i] >= TMO) begin m_wait[i] = 0; m_err[i] = 1'b1; end
        else m_wait[i] = m_wait[i] + 1;
      end else if (dmem_req && !dmem_ack) begin m_wait[i] = 1; m_bub[i] = 0; end
      else if (br_taken) m_bub[i] = 0;
      else if (m_bub[i] > 0) m_bub[i] = m_bub[i] - 1;
      else if (spec_hazard()) m_bub[i] = lbs[i] - 1;
    end
  endtask

  // compares both instances against the model on the falling edge, then advances the model
  task automatic do_cycle(input string tag);
    logic [5:0]  e [2];
    logic [31:0] es, ef;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      e[i] = model_out(i);
`ifdef HAZ_PERF_CNT_EN
      es = rst ? m_scnt[i] : 32'd0;
      ef = rst ? m_fcnt[i] : 32'd0;
`else
      es = 32'd0;
      ef = 32'd0;
`endif
      chk($sformatf("%s_dut%0d_ctl", tag, lbs[i]), {26'd0, (i == 0) ? v1 : v3}, {26'd0, e[i]});
      chk($sformatf("%s_dut%0d_scnt", tag, lbs[i]), (i == 0) ? a_scnt : b_scnt, es);
      chk($sformatf("%s_dut%0d_fcnt", tag, lbs[i]), (i == 0) ? a_fcnt : b_fcnt, ef);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_update(i, e[i]);
    #1;
  endtask

  task automatic idle();
    de_rs1 = 5'd0; de_rs2 = 5'd0; ex_rd = 5'd0;
    de_use_rs1 = 1'b0; de_use_rs2 = 1'b0; ex_is_load = 1'b0; ex_reg_wr = 1'b0;
    br_taken = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic set_load_use();
    idle();
    ex_is_load = 1'b1; ex_reg_wr = 1'b1; ex_rd = 5'd5; de_use_rs1 = 1'b1; de_rs1 = 5'd5;
  endtask

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, ld, wr, br, req, ack;
    logic [5:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [6:0] ctl, input logic [5:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    {v.u1, v.u2, v.ld, v.wr, v.br, v.req, v.ack} = ctl;
    v.exp = exp;
    return v;
  endfunction

  vec_t tbl [10];
  int   cnt, cnt3;

  initial begin
    // ctl = {use_rs1, use_rs2, is_load, reg_wr, br, req, ack}; expectations for LOAD_BUBBLES=1
    tbl[0] = mk(5'd5,  5'd0,  5'd5,  7'b1011000, E_BUB);
    tbl[1] = mk(5'd0,  5'd0,  5'd0,  7'b1111000, E_IDLE);
    tbl[2] = mk(5'd1,  5'd9,  5'd9,  7'b0111000, E_BUB);
    tbl[3] = mk(5'd1,  5'd9,  5'd9,  7'b1011000, E_IDLE);
    tbl[4] = mk(5'd7,  5'd7,  5'd7,  7'b1101000, E_IDLE);
    tbl[5] = mk(5'd7,  5'd7,  5'd7,  7'b1110000, E_IDLE);
    tbl[6] = mk(5'd5,  5'd0,  5'd5,  7'b1011100, E_FL);
    tbl[7] = mk(5'd0,  5'd0,  5'd0,  7'b0000011, E_IDLE);
    tbl[8] = mk(5'd0,  5'd0,  5'd0,  7'b0000111, E_FL);
    tbl[9] = mk(5'd31, 5'd30, 5'd31, 7'b1111000, E_BUB);

    for (int i = 0; i < 2; i++) begin
      m_wait[i] = 0; m_bub[i] = 0; m_err[i] = 1'b0; m_scnt[i] = 32'd0; m_fcnt[i] = 32'd0;
    end
    idle();
    rst = 1'b0;
    #1;
    chk("reset_ctl", {26'd0, v1}, 32'd0);
    chk("reset_scnt", a_scnt, 32'd0);
    do_cycle("reset");
    do_cycle("reset");
    rst = 1'b1;
    do_cycle("post_reset");

    for (int k = 0; k < 10; k++) begin
      de_rs1 = tbl[k].rs1; de_rs2 = tbl[k].rs2; ex_rd = tbl[k].rd;
      de_use_rs1 = tbl[k].u1; de_use_rs2 = tbl[k].u2; ex_is_load = tbl[k].ld; ex_reg_wr = tbl[k].wr;
      br_taken = tbl[k].br; dmem_req = tbl[k].req; dmem_ack = tbl[k].ack;
      #1;
      chk($sformatf("table_%0d", k), {26'd0, v1}, {26'd0, tbl[k].exp});
      do_cycle("table");
      idle();
      for (int j = 0; j < 3; j++) do_cycle("table_drain");
    end

    // memory ack arriving on the fourth cycle of a request
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      idle(); dmem_req = 1'b1; dmem_ack = (c == 3);
      #1;
      if (a_spc && a_sfd && a_sdx) cnt++;
      do_cycle("mem_ack3");
    end
    chk("mem_ack3_stall_cycles", cnt, 32'd3);
    idle();
    do_cycle("mem_ack3_idle");

    // branch held across a memory wait flushes only after the ack cycle
    idle(); dmem_req = 1'b1;
    do_cycle("br_wait");
    br_taken = 1'b1;
    #1;
    chk("br_wait_no_flush", {31'd0, a_ffd}, 32'd0);
    do_cycle("br_wait");
    dmem_ack = 1'b1;
    #1;
    chk("br_ack_cycle_quiet", {26'd0, v1}, 32'd0);
    do_cycle("br_wait");
    dmem_req = 1'b0; dmem_ack = 1'b0;
    #1;
    chk("br_after_ack_flush", {26'd0, v1}, {26'd0, E_FL});
    do_cycle("br_wait");
    idle();
    do_cycle("br_wait_idle");

    // multi-bubble instance: three bubbles, then abort by branch, then preemption by memory wait
    set_load_use();
    cnt = 0; cnt3 = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (a_spc && a_fdx) cnt++;
      if (b_spc && b_sfd && b_fdx && !b_sdx) cnt3++;
      do_cycle("lb3");
      idle();
    end
    chk("lb1_bubbles", cnt, 32'd1);
    chk("lb3_bubbles", cnt3, 32'd3);
    set_load_use();
    do_cycle("lb3_br");
    idle(); br_taken = 1'b1;
    #1;
    chk("lb3_branch_abort", {26'd0, v3}, {26'd0, E_FL});
    do_cycle("lb3_br");
    idle();
    #1;
    chk("lb3_after_abort", {26'd0, v3}, 32'd0);
    do_cycle("lb3_br");
    set_load_use();
    do_cycle("lb3_mem");
    idle(); dmem_req = 1'b1;
    #1;
    chk("lb3_mem_preempt", {26'd0, v3}, {26'd0, E_MEM});
    do_cycle("lb3_mem");
    dmem_ack = 1'b1;
    do_cycle("lb3_mem");
    idle();
    do_cycle("lb3_mem_idle");

    // memory timeout: eight stall cycles, then a sticky error
    cnt = 0;
    for (int c = 0; c < 9; c++) begin
      idle(); dmem_req = 1'b1;
      #1;
      if (a_spc) cnt++;
      do_cycle("timeout");
    end
    chk("timeout_stall_cycles", cnt, 32'd8);
    idle();
    #1;
    chk("timeout_mem_err", {31'd0, a_err}, 32'd1);
    for (int c = 0; c < 4; c++) do_cycle("timeout_hold");
    chk("timeout_err_sticky", {31'd0, a_err}, 32'd1);

    // reset in the middle of a memory wait
    dmem_req = 1'b1;
    do_cycle("rst_wait");
    rst = 1'b0;
    #1;
    chk("rst_wait_outputs", {26'd0, v1}, 32'd0);
    do_cycle("rst_wait");
    rst = 1'b1; dmem_req = 1'b0;
    #1;
    chk("rst_wait_release", {26'd0, v1}, 32'd0);
    do_cycle("rst_wait");

    // five stall cycles after reset
    for (int c = 0; c < 5; c++) begin
      set_load_use();
      do_cycle("perf");
    end
    idle();
    #1;
`ifdef HAZ_PERF_CNT_EN
    chk("perf_stall_cnt", a_scnt, 32'd5);
`else
    chk("perf_stall_cnt", a_scnt, 32'd0);
`endif
    do_cycle("perf");

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 99) != 0);
      de_rs1     = 5'($urandom_range(0, 3));
      de_rs2     = 5'($urandom_range(0, 3));
      ex_rd      = 5'($urandom_range(0, 3));
      de_use_rs1 = 1'($urandom_range(0, 1));
      de_use_rs2 = 1'($urandom_range(0, 1));
      ex_is_load = 1'($urandom_range(0, 1));
      ex_reg_wr  = ($urandom_range(0, 3) != 0);
      br_taken   = ($urandom_range(0, 5) == 0);
      dmem_req   = ($urandom_range(0, 4) == 0);
      dmem_ack   = ($urandom_range(0, 6) == 0);
      do_cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline control unit that sequences the fetch/decode and decode/execute pipeline registers. It generates stall and flush controls from three sources:
- load-use data hazards
- taken branches
- multi-cycle data-memory accesses (req/ack handshake)
It sits beside the datapath and drives the stall/flush inputs of the PC, F/DE and DE/EX registers.

Parameters:
LOAD_BUBBLES, 1, bubbles inserted per load-use hazard (1..4)
MEM_TIMEOUT, 64, cycles waiting for dmem_ack before abort (>=2)
REG_AW, 5, register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
de_rs1  in  REG_AW  rs1 index of instruction in decode
de_rs2  in  REG_AW  rs2 index of instruction in decode
de_use_rs1  in  1  decode instruction reads rs1
de_use_rs2  in  1  decode instruction reads rs2
ex_rd  in  REG_AW  rd index of instruction in execute
ex_is_load  in  1  execute instruction is a load
ex_reg_wr  in  1  execute instruction writes rd
br_taken  in  1  branch/jump resolved taken in execute
dmem_req  in  1  data-memory request active
dmem_ack  in  1  data-memory completion
stall_pc  out  1  hold PC
stall_fd  out  1  hold F/DE registers
stall_dx  out  1  hold DE/EX registers
flush_fd  out  1  load NOP into F/DE IR
flush_dx  out  1  load NOP into DE/EX
mem_err  out  1  sticky memory-timeout flag
stall_cnt  out  32  stall-cycle counter (optional feature)
flush_cnt  out  32  flush-event counter (optional feature)

Behaviour:
- Reset: rst==0 at posedge → state RUN, bubble counter 0, timeout counter 0, mem_err 0, counters 0. While in reset all outputs read 0.
- Outputs are combinational from state and inputs, so stalls take effect in the same cycle. State and counters are registered.
- States: RUN, LOAD_STALL, MEM_WAIT.
- hazard = ex_is_load & ex_reg_wr & ex_rd!=0 & ((de_use_rs1 & de_rs1==ex_rd) | (de_use_rs2 & de_rs2==ex_rd)).
- Priority, highest first: memory wait > branch flush > load-use.
- RUN, dmem_req & !dmem_ack:
  - stall_pc = stall_fd = stall_dx = 1, no flushes.
  - Go to MEM_WAIT with timeout counter = 1.
- RUN, dmem_req & dmem_ack same cycle: no stall.
- MEM_WAIT:
  - All three stalls held at 1.
  - On dmem_ack: go to RUN; stalls deassert in the ack cycle.
  - If the timeout counter reaches MEM_TIMEOUT without ack: set mem_err, drop stalls, go to RUN.
  - mem_err clears only on reset.
- RUN, br_taken (no mem wait): flush_fd = flush_dx = 1, no stalls. Any hazard in that cycle is ignored.
- Branch during MEM_WAIT: held, not flushed. br_taken stays asserted because the execute stage is stalled, so the flush is applied in the first RUN cycle after ack.
- RUN, hazard (no mem wait, no branch):
  - stall_pc = stall_fd = 1, flush_dx = 1 (bubble).
  - If LOAD_BUBBLES>1: go to LOAD_STALL with counter = LOAD_BUBBLES-1; else stay in RUN.
- LOAD_STALL:
  - Same outputs as a hazard cycle; decrement the counter; go to RUN when it reaches 0.
  - br_taken aborts to RUN with the flush applied.
  - dmem_req & !dmem_ack goes to MEM_WAIT.
- Simultaneous stall_fd and flush_fd never occur.
- Reset mid-stall or mid-wait returns to RUN immediately and clears all counters.

Optional Feature:
HAZ_PERF_CNT_EN:
- When defined: stall_cnt increments every cycle stall_pc==1; flush_cnt increments every cycle flush_fd==1. Both wrap at 2^32.
- When undefined: both ports tied to 0 and no counter flops are synthesised.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state enum hz_state_t {RUN, LOAD_STALL, MEM_WAIT}
  - NOP_INSTR = 32'h0000_0013
  - REG_AW default
- Sub-module load_use_detect: combinational hazard comparator, reusable by the forwarding logic.

Test Plan:
- Load-use: ex_is_load=1, ex_reg_wr=1, ex_rd=5, de_use_rs1=1, de_rs1=5 → stall_pc=stall_fd=flush_dx=1 for exactly 1 cycle (LOAD_BUBBLES=1); ex_rd=0 → no stall.
- Taken branch with a concurrent hazard → flush_fd=flush_dx=1 for 1 cycle, no stall asserted.
- dmem_req high, ack after 3 cycles → stalls high for 3 cycles, low in the ack cycle; ack in the req cycle → no stall.
- dmem_req with no ack, MEM_TIMEOUT=8 → stalls high 8 cycles, then mem_err=1 and stalls 0; mem_err stays set until rst=0.
- br_taken asserted during MEM_WAIT → no flush until ack; flush_fd=1 in the first cycle after ack.
- rst=0 during MEM_WAIT → next cycle all outputs 0, state RUN. With HAZ_PERF_CNT_EN, 5 stall cycles → stall_cnt=5.
